fifo_prog: RTL and testbench

Parametrised synchronous FIFO succeeding the fixed 16×8 FIFO used on the test channel. It adds independent width and depth parameters, runtime-programmable almost-full and almost-empty thresholds, an occupancy count, a synchronous flush, and a registered read-valid strobe. It sits between a single-clock producer and consumer. First-word-fall-through is a compile-time option.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_mem.sv | 22 ++
 rtl/fifo_prog.sv | 112 +++++++++++
 tb/tb_fifo_prog.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable FIFO.
package fifo_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
        logic wr_ack;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(FIFO_DEPTH)-1:0] waddr,
    input  logic [FIFO_WIDTH-1:0]         wdata,
    input  logic [$clog2(FIFO_DEPTH)-1:0] raddr,
    output logic [FIFO_WIDTH-1:0]         rdata
);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog.sv
// Parametrised synchronous FIFO with programmable almost flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_prog
    import fifo_pkg::*;
#(
    parameter  int FIFO_WIDTH = 16,
    parameter  int FIFO_DEPTH = 8,
    localparam int CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [FIFO_WIDTH-1:0] mem_rdata;

    assign full        = (cnt == DEPTH_C);
    assign empty       = (cnt == '0);
    assign almostfull  = (cnt >= af_thresh);
    assign almostempty = (cnt <= ae_thresh);
    assign count       = cnt;

    // flush masks both requests so nothing is acknowledged that cycle
    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    fifo_mem #(
        .FIFO_WIDTH(FIFO_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(data_in),
        .raddr(rd_ptr),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            if (wr_acc && !rd_acc) cnt <= cnt + CNT_W'(1);
            else if (rd_acc && !wr_acc) cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_acc;
            overflow  <= wr_en && full && !flush;
            underflow <= rd_en && empty && !flush;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = mem_rdata;
    assign rd_valid = !empty;
`else
    logic [FIFO_WIDTH-1:0] data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) data_q <= mem_rdata;
        end
    end

    assign data_out = data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// Scoreboard-based bench for fifo_prog (FIFO_WIDTH=16, FIFO_DEPTH=8).
module tb_fifo_prog;
    import fifo_pkg::*;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] din;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  af;
    logic [3:0]  ae;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        wr_ack;
    logic        overflow;
    logic        underflow;
    logic        full;
    logic        empty;
    logic        almostfull;
    logic        almostempty;
    logic [3:0]  count;

    int          checks   = 0;
    int          failures = 0;
    int          mcount   = 0;
    logic [15:0] sbq[$];
    logic [15:0] e_dout   = '0;
    bit          e_ack, e_ovf, e_udf, e_rv;
    fifo_status_t st;

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush), .data_in(din),
        .wr_en(wr_en), .rd_en(rd_en),
        .af_thresh(af), .ae_thresh(ae),
        .data_out(data_out), .rd_valid(rd_valid), .wr_ack(wr_ack),
        .overflow(overflow), .underflow(underflow),
        .full(full), .empty(empty),
        .almostfull(almostfull), .almostempty(almostempty),
        .count(count)
    );

    always #5 clk = ~clk;

    assign st = {full, empty, almostfull, almostempty,
                 wr_ack, overflow, underflow};

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

    // One clock with the model updated from the pre-edge state.
    task automatic tick();
        bit wa, ra;
        wa    = !flush && wr_en && (mcount < D);
        ra    = !flush && rd_en && (mcount > 0);
        e_ack = wa;
        e_ovf = !flush && wr_en && (mcount == D);
        e_udf = !flush && rd_en && (mcount == 0);
        e_rv  = ra;
        if (ra) e_dout = sbq.pop_front();
        if (wa) sbq.push_back(din);
        if (flush) sbq.delete();
        @(posedge clk);
        #1;
        if (flush) mcount = 0;
        else mcount = mcount + int'(wa) - int'(ra);
    endtask

    task automatic idle();
        wr_en = 0; rd_en = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); din = '0; af = 4'd8; ae = 4'd2;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (st !== 7'b0101000) begin
            failures++;
            $display("FAIL reset_status: got %b want %b", st, 7'b0101000);
        end
        checks++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_cnt: count=%0d rd_valid=%b want 0 0", count, rd_valid);
        end
`ifndef FIFO_FWFT_EN
        checks++;
        if (data_out !== 16'h0) begin
            failures++;
            $display("FAIL reset_dout: got %h want 0000", data_out);
        end
`endif
        af = 4'd0;
        #1;
        checks++;
        if (almostfull !== 1'b1) begin
            failures++;
            $display("FAIL reset_af0: got %b want 1", almostfull);
        end
        af = 4'd8;
        @(negedge clk);
        rst = 0;
        mcount = 0; sbq.delete(); e_dout = '0;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < D; i++) begin
            wr_en = 1; din = 16'hA001 + 16'(i);
            tick();
            checks++;
            if (wr_ack !== 1'b1 || count !== 4'(mcount)) begin
                failures++;
                $display("FAIL fill_%0d: wr_ack=%b count=%0d want 1 %0d", i, wr_ack, count, mcount);
            end
        end
        checks++;
        if (full !== 1'b1 || count !== 4'd8) begin
            failures++;
            $display("FAIL full_flag: full=%b count=%0d want 1 8", full, count);
        end
        din = 16'hA009;
        tick();
        checks++;
        if (overflow !== e_ovf || wr_ack !== 1'b0 || count !== 4'd8) begin
            failures++;
            $display("FAIL overflow: ovf=%b ack=%b count=%0d want %b 0 8", overflow, wr_ack, count, e_ovf);
        end
        idle();
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_pulse: got %b want 0", overflow);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < D; i++) begin
            rd_en = 1;
            tick();
            checks++;
            if (rd_valid !== 1'b1 || data_out !== e_dout || e_dout !== 16'hA001 + 16'(i)) begin
                failures++;
                $display("FAIL drain_%0d: rv=%b dout=%h want 1 %h", i, rd_valid, data_out, 16'hA001 + 16'(i));
            end
        end
        tick();
        checks++;
        if (underflow !== 1'b1 || empty !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL underflow: udf=%b empty=%b rv=%b want 1 1 0", underflow, empty, rd_valid);
        end
        checks++;
        if (data_out !== 16'hA008) begin
            failures++;
            $display("FAIL dout_hold: got %h want a008", data_out);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; din = 16'hB000 + 16'(i);
            tick();
        end
        checks++;
        if (count !== 4'd4) begin
            failures++;
            $display("FAIL b2b_pre: count=%0d want 4", count);
        end
        for (int i = 0; i < 10; i++) begin
            wr_en = 1; rd_en = 1; din = 16'hC000 + 16'(i);
            tick();
            checks++;
            if (count !== 4'd4 || rd_valid !== e_rv || data_out !== e_dout || wr_ack !== e_ack) begin
                failures++;
                $display("FAIL b2b_%0d: count=%0d rv=%b dout=%h ack=%b want 4 %b %h %b",
                         i, count, rd_valid, data_out, wr_ack, e_rv, e_dout, e_ack);
            end
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rd_en = 1;
            tick();
            checks++;
            if (rd_valid !== 1'b1 || data_out !== e_dout || e_dout !== 16'hC006 + 16'(i)) begin
                failures++;
                $display("FAIL b2b_tail_%0d: rv=%b dout=%h want 1 %h", i, rd_valid, data_out, 16'hC006 + 16'(i));
            end
        end
        idle();
    endtask

    task automatic test_thresholds();
        af = 4'd6; ae = 4'd2;
        #1;
        checks++;
        if (almostempty !== 1'b1 || almostfull !== 1'b0) begin
            failures++;
            $display("FAIL thr_c0: ae=%b af=%b want 1 0", almostempty, almostfull);
        end
        for (int i = 0; i < D; i++) begin
            wr_en = 1; din = 16'hD000 + 16'(i);
            tick();
            checks++;
            if (almostempty !== (mcount <= 2) || almostfull !== (mcount >= 6)) begin
                failures++;
                $display("FAIL thr_c%0d: ae=%b af=%b want %b %b",
                         mcount, almostempty, almostfull, mcount <= 2, mcount >= 6);
            end
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rd_en = 1;
            tick();
            checks++;
            if (data_out !== e_dout) begin
                failures++;
                $display("FAIL thr_rd_%0d: got %h want %h", i, data_out, e_dout);
            end
        end
        idle();
        af = 4'd5;
        #1;
        checks++;
        if (almostfull !== 1'b0) begin
            failures++;
            $display("FAIL thr_af5: got %b want 0", almostfull);
        end
        af = 4'd3;
        #1;
        checks++;
        if (almostfull !== 1'b1 || count !== 4'd4) begin
            failures++;
            $display("FAIL thr_af3: af=%b count=%0d want 1 4", almostfull, count);
        end
        af = 4'd8; ae = 4'd0;
    endtask

    task automatic test_flush();
        logic [15:0] held;
        wr_en = 1; din = 16'hE000;
        tick();
        checks++;
        if (count !== 4'd5) begin
            failures++;
            $display("FAIL flush_pre: count=%0d want 5", count);
        end
        held = e_dout;
        flush = 1; wr_en = 1; rd_en = 1; din = 16'hE001;
        tick();
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || wr_ack !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush: count=%0d empty=%b ack=%b rv=%b want 0 1 0 0",
                     count, empty, wr_ack, rd_valid);
        end
        checks++;
        if (data_out !== held || underflow !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL flush_hold: dout=%h udf=%b ovf=%b want %h 0 0", data_out, underflow, overflow, held);
        end
        idle();
        wr_en = 1; din = 16'hF00D;
        tick();
        idle(); rd_en = 1;
        tick();
        idle();
        tick();
        checks++;
        if (data_out !== e_dout || e_dout !== 16'hF00D) begin
            failures++;
            $display("FAIL post_flush: got %h want f00d", data_out);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; din = 16'h5500 + 16'(i);
            tick();
        end
        #2;
        rst = 1;
        #1;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || wr_ack !== 1'b0) begin
            failures++;
            $display("FAIL async_rst: count=%0d empty=%b ack=%b want 0 1 0", count, empty, wr_ack);
        end
        idle();
        @(negedge clk);
        rst = 0;
        mcount = 0; sbq.delete(); e_dout = '0;
    endtask

`ifdef FIFO_FWFT_EN
    task automatic test_fwft();
        wr_en = 1; din = 16'h1234;
        tick();
        idle();
        checks++;
        if (data_out !== 16'h1234 || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL fwft_head: dout=%h rv=%b want 1234 1", data_out, rd_valid);
        end
        rd_en = 1;
        tick();
        idle();
        checks++;
        if (empty !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL fwft_pop: empty=%b rv=%b want 1 0", empty, rd_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_overflow();
`ifdef FIFO_FWFT_EN
        idle();
        test_async_reset();
        test_fwft();
`else
        test_drain_underflow();
        test_back_to_back();
        test_thresholds();
        test_flush();
        test_async_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
